// File: rtl/riscv_rf_pkg.sv
// Shared types and helpers for the multi-port integer register file.
package riscv_rf_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return r;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: x0 forcing, clear masking and write bypass.
module rf_read_port
  import riscv_rf_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NWRITE = 2,
  parameter int BYPASS = 1,
  parameter int AW     = clog2(NREGS)
) (
  input  logic [AW-1:0]          addr,
  input  logic [NREGS*XLEN-1:0]  regs_flat,
  input  logic [NREGS-1:0]       pend_vec,
  input  logic [NWRITE-1:0]      wr_en,
  input  logic [NWRITE*AW-1:0]   wr_addr,
  input  logic [NWRITE*XLEN-1:0] wr_data,
  input  logic                   claim_en,
  input  logic [AW-1:0]          claim_addr,
  input  logic                   busy,
  output logic [XLEN-1:0]        data,
  output logic                   pending
);

  logic hit;

  always_comb begin
    data    = regs_flat[addr*XLEN +: XLEN];
    pending = pend_vec[addr];
    hit     = 1'b0;
    // Ascending scan so the highest-index write port ends up forwarded.
    for (int j = 0; j < NWRITE; j++) begin
      if (BYPASS != 0 && wr_en[j] && wr_addr[j*AW +: AW] == addr) begin
        hit  = 1'b1;
        data = wr_data[j*XLEN +: XLEN];
      end
    end
    if (hit) pending = claim_en && (claim_addr == addr);
    if (busy || addr == '0) begin
      data    = '0;
      pending = 1'b0;
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with post-reset sequential clear, write bypass
// and a per-register pending bit set by issue claims.
//
// state    | meaning
// RF_CLEAR | zeroing regs[clr_ptr] one per cycle; writes/claims ignored, reads 0
// RF_READY | normal operation
module register_file_mp
  import riscv_rf_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2,
  parameter int BYPASS = 1,
  localparam int AW    = clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREAD*AW-1:0]    rd_addr,
  output logic [NREAD*XLEN-1:0]  rd_data,
  output logic [NREAD-1:0]       rd_pending,
  input  logic [NWRITE-1:0]      wr_en,
  input  logic [NWRITE*AW-1:0]   wr_addr,
  input  logic [NWRITE*XLEN-1:0] wr_data,
  input  logic                   claim_en,
  input  logic [AW-1:0]          claim_addr,
  output logic                   init_busy
);

  rf_state_t             state_q, state_d;
  logic [AW-1:0]         clr_ptr_q, clr_ptr_d;
  logic [XLEN-1:0]       regs_q [1:NREGS-1];
  logic [NREGS-1:1]      pend_q;
  logic [NREGS*XLEN-1:0] regs_flat;
  logic [NREGS-1:0]      pend_vec;

  assign init_busy = (state_q == RF_CLEAR);
  assign pend_vec  = {pend_q, 1'b0};

  always_comb begin
    regs_flat = '0;
    for (int r = 1; r < NREGS; r++) regs_flat[r*XLEN +: XLEN] = regs_q[r];
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (state_q == RF_CLEAR) begin
      if (clr_ptr_q == AW'(NREGS - 1)) state_d = RF_READY;
      else                             clr_ptr_d = clr_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RF_CLEAR;
      clr_ptr_q <= AW'(1);
      pend_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      if (state_q == RF_READY) begin
        // Claim is applied after the writes so it wins on a same-address collision.
        for (int r = 1; r < NREGS; r++) begin
          for (int j = 0; j < NWRITE; j++)
            if (wr_en[j] && wr_addr[j*AW +: AW] == AW'(r)) pend_q[r] <= 1'b0;
          if (claim_en && claim_addr == AW'(r)) pend_q[r] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 1; r < NREGS; r++) begin
        if (state_q == RF_CLEAR) begin
          if (clr_ptr_q == AW'(r)) regs_q[r] <= '0;
        end else begin
          for (int j = 0; j < NWRITE; j++)
            if (wr_en[j] && wr_addr[j*AW +: AW] == AW'(r))
              regs_q[r] <= wr_data[j*XLEN +: XLEN];
        end
      end
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    rf_read_port #(
      .XLEN(XLEN), .NREGS(NREGS), .NWRITE(NWRITE), .BYPASS(BYPASS), .AW(AW)
    ) u_rd (
      .addr       (rd_addr[i*AW +: AW]),
      .regs_flat  (regs_flat),
      .pend_vec   (pend_vec),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .claim_en   (claim_en),
      .claim_addr (claim_addr),
      .busy       (init_busy),
      .data       (rd_data[i*XLEN +: XLEN]),
      .pending    (rd_pending[i])
    );
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: a bypassing and a non-bypassing instance share stimulus.
module tb_register_file_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        claim_en;
  logic [4:0]  claim_addr;
  logic [63:0] rd_data_b, rd_data_n;
  logic [1:0]  rd_pending_b, rd_pending_n;
  logic        init_busy_b, init_busy_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  register_file_mp #(.BYPASS(1)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_pending(rd_pending_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .claim_en(claim_en),
    .claim_addr(claim_addr), .init_busy(init_busy_b)
  );

  register_file_mp #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_pending(rd_pending_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .claim_en(claim_en),
    .claim_addr(claim_addr), .init_busy(init_busy_n)
  );

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        ce;
    logic [4:0]  ca;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] ed0;
    logic        ep0;
    logic [31:0] ed1;
    logic        ep1;
  } vec_t;

  typedef struct {
    int          sel;
    logic [31:0] d;
    logic        p;
  } exp_t;

  vec_t        vecs [15];
  exp_t        sbq [$];
  logic [31:0] mregs [32];
  logic        mpend [32];

  function automatic vec_t mk(logic [1:0] we, logic [4:0] wa0, logic [31:0] wd0,
                              logic [4:0] wa1, logic [31:0] wd1, logic ce, logic [4:0] ca,
                              logic [4:0] ra0, logic [4:0] ra1, logic [31:0] ed0, logic ep0,
                              logic [31:0] ed1, logic ep1);
    vec_t v;
    v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.ce = ce; v.ca = ca; v.ra0 = ra0; v.ra1 = ra1;
    v.ed0 = ed0; v.ep0 = ep0; v.ed1 = ed1; v.ep1 = ep1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = '0; wr_addr = '0; wr_data = '0; claim_en = 1'b0; claim_addr = '0;
  endtask

  // Counts busy cycles on both instances after a reset edge; bounded.
  task automatic count_busy(input string tag, input int write_at);
    int nb, nn, n;
    nb = 0; nn = 0; n = 0;
    while ((init_busy_b || init_busy_n) && n < 100) begin
      if (n == write_at) begin
        wr_en = 2'b01; wr_addr = {5'd0, 5'd12}; wr_data = {32'd0, 32'hCAFEF00D};
        claim_en = 1'b1; claim_addr = 5'd12;
      end else idle_inputs();
      if (init_busy_b) nb++;
      if (init_busy_n) nn++;
      n++;
      tick();
    end
    idle_inputs();
    check({tag, "_busy_cycles_b"}, nb, 31);
    check({tag, "_busy_cycles_nb"}, nn, 31);
  endtask

  task automatic read_pair(input string tag, input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
    @(negedge clk);
    check($sformatf("%s_x%0d_b", tag, a0), rd_data_b[31:0], 32'd0);
    check($sformatf("%s_x%0d_b", tag, a1), rd_data_b[63:32], 32'd0);
    check($sformatf("%s_x%0d_nb", tag, a0), rd_data_n[31:0], 32'd0);
    check($sformatf("%s_x%0d_nb", tag, a1), rd_data_n[63:32], 32'd0);
    check($sformatf("%s_pend_%0d_%0d", tag, a0, a1), {28'd0, rd_pending_b, rd_pending_n}, 32'd0);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    rd_addr = '0;
    idle_inputs();

    vecs[0]  = mk(2'b01, 5, 32'hDEADBEEF, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 0, 0, 0);
    vecs[1]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 5, 5, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0);
    vecs[2]  = mk(2'b11, 7, 32'h11, 7, 32'h22, 0, 0, 7, 5, 32'h22, 0, 32'hDEADBEEF, 0);
    vecs[3]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 7, 0, 32'h22, 0, 0, 0);
    vecs[4]  = mk(2'b00, 0, 0, 0, 0, 1, 9, 9, 7, 0, 0, 32'h22, 0);
    vecs[5]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 9, 7, 0, 1, 32'h22, 0);
    vecs[6]  = mk(2'b01, 9, 32'h5, 0, 0, 0, 0, 9, 9, 32'h5, 0, 32'h5, 0);
    vecs[7]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 9, 0, 32'h5, 0, 0, 0);
    vecs[8]  = mk(2'b10, 0, 0, 9, 32'h5, 1, 9, 9, 7, 32'h5, 1, 32'h22, 0);
    vecs[9]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 9, 0, 32'h5, 1, 0, 0);
    vecs[10] = mk(2'b11, 0, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[11] = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 32'h5, 1);
    vecs[12] = mk(2'b11, 3, 32'hAAAA, 4, 32'hBBBB, 0, 0, 3, 4, 32'hAAAA, 0, 32'hBBBB, 0);
    vecs[13] = mk(2'b01, 31, 32'h12345678, 0, 0, 1, 31, 31, 3, 32'h12345678, 1, 32'hAAAA, 0);
    vecs[14] = mk(2'b00, 0, 0, 0, 0, 0, 0, 31, 4, 32'h12345678, 1, 32'hBBBB, 0);

    // Initial clear sequence and all-zero contents afterwards.
    tick();
    rst = 1'b0;
    count_busy("init", -1);
    for (int a = 0; a < 32; a += 2) read_pair("post_init", 5'(a), 5'(a + 1));

    for (int r = 0; r < 32; r++) begin
      mregs[r] = '0;
      mpend[r] = 1'b0;
    end

    // Table-driven READY traffic through the scoreboard.
    for (int i = 0; i < 15; i++) begin
      vec_t v;
      exp_t e;
      v = vecs[i];
      wr_en = v.we; wr_addr = {v.wa1, v.wa0}; wr_data = {v.wd1, v.wd0};
      claim_en = v.ce; claim_addr = v.ca; rd_addr = {v.ra1, v.ra0};
      sbq.push_back('{0, v.ed0, v.ep0});
      sbq.push_back('{1, v.ed1, v.ep1});
      sbq.push_back('{2, (v.ra0 == 0) ? 32'd0 : mregs[v.ra0], (v.ra0 == 0) ? 1'b0 : mpend[v.ra0]});
      sbq.push_back('{3, (v.ra1 == 0) ? 32'd0 : mregs[v.ra1], (v.ra1 == 0) ? 1'b0 : mpend[v.ra1]});
      @(negedge clk);
      while (sbq.size() > 0) begin
        logic [31:0] ad;
        logic        ap;
        e = sbq.pop_front();
        case (e.sel)
          0:       begin ad = rd_data_b[31:0];  ap = rd_pending_b[0]; end
          1:       begin ad = rd_data_b[63:32]; ap = rd_pending_b[1]; end
          2:       begin ad = rd_data_n[31:0];  ap = rd_pending_n[0]; end
          default: begin ad = rd_data_n[63:32]; ap = rd_pending_n[1]; end
        endcase
        check($sformatf("vec%0d_data_s%0d", i, e.sel), ad, e.d);
        check($sformatf("vec%0d_pend_s%0d", i, e.sel), {31'd0, ap}, {31'd0, e.p});
      end
      @(posedge clk);
      if (v.we[0] && v.wa0 != 0) begin mregs[v.wa0] = v.wd0; mpend[v.wa0] = 1'b0; end
      if (v.we[1] && v.wa1 != 0) begin mregs[v.wa1] = v.wd1; mpend[v.wa1] = 1'b0; end
      if (v.ce && v.ca != 0) mpend[v.ca] = 1'b1;
      #1;
    end
    idle_inputs();

    // Reset again, interrupt the clear at cycle 10, then drop a write during CLEAR.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check($sformatf("pre_restart_busy%0d", k), {30'd0, init_busy_b, init_busy_n}, 32'd3);
      if (k == 1) begin
        rd_addr = {5'd9, 5'd5};
        wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'd0, 32'h77};
        #1;
        check("clear_rd_x5_b", rd_data_b[31:0], 32'd0);
        check("clear_rd_x9_b", rd_data_b[63:32], 32'd0);
        check("clear_rd_pend", {28'd0, rd_pending_b, rd_pending_n}, 32'd0);
      end else idle_inputs();
      tick();
    end
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_busy("restart", 19);
    read_pair("after_restart", 5'd12, 5'd5);
    read_pair("after_restart", 5'd31, 5'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
